seq_det_prog: RTL and testbench

SEQ_DET_PROG -- requirements
Module: seq_det_prog

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_match.sv | 31 +++
 rtl/seq_det_prog.sv | 117 +++++++++++
 tb/tb_seq_det_prog.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Optional match counter is enabled by defining SEQ_DET_CNT_EN.
package seq_det_pkg;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  // Width needed to hold a length value in the range 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Combinational masked compare: true when the low len bits of hist equal those of pat.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic [PAT_W-1:0]        hist,
  input  logic [PAT_W-1:0]        pat,
  input  logic [len_w(PAT_W)-1:0] len,
  output logic                    eq
);

  localparam int LEN_W = len_w(PAT_W);

  logic [PAT_W-1:0] mask_s;

  // Build a mask that keeps only the active pattern bits.
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      if (LEN_W'(i) < len) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  assign eq = (((hist ^ pat) & mask_s) == {PAT_W{1'b0}});

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with overlap control and registered Moore flag.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'b0000_1101),
  parameter int               RST_LEN = 4,
  parameter logic             RST_OVL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x,
  input  logic                    x_valid,
  input  logic                    cfg_load,
  input  logic [PAT_W-1:0]        cfg_pat,
  input  logic [len_w(PAT_W)-1:0] cfg_len,
  input  logic                    cfg_ovl,
  output logic                    z,
  output logic [CNT_W-1:0]        match_cnt
);

  localparam int LEN_W = len_w(PAT_W);

  logic [PAT_W-1:0] hist_r, hist_nxt_s, hist_shift_s;
  logic [LEN_W-1:0] fill_r, fill_nxt_s, fill_inc_s;
  logic [PAT_W-1:0] pat_r, pat_nxt_s;
  logic [LEN_W-1:0] len_r, len_nxt_s;
  logic             ovl_r, ovl_nxt_s;
  logic             z_r, z_nxt_s;
  logic             eq_s, match_s;

  assign hist_shift_s = {hist_r[PAT_W-2:0], x};
  assign fill_inc_s   = (fill_r >= LEN_W'(PAT_W)) ? fill_r : fill_r + LEN_W'(1);

  seq_det_match #(.PAT_W(PAT_W)) u_match (
    .hist (hist_shift_s),
    .pat  (pat_r),
    .len  (len_r),
    .eq   (eq_s)
  );

  // A zero length never matches, even though the masked compare is trivially true.
  assign match_s = x_valid & ~cfg_load & (len_r != LEN_W'(0)) &
                   (fill_inc_s >= len_r) & eq_s;

  // Next-state selection: load beats sampling, bubbles only drop z.
  always_comb begin
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    pat_nxt_s  = pat_r;
    len_nxt_s  = len_r;
    ovl_nxt_s  = ovl_r;
    z_nxt_s    = 1'b0;
    if (cfg_load) begin
      pat_nxt_s  = cfg_pat;
      len_nxt_s  = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
      ovl_nxt_s  = cfg_ovl;
      hist_nxt_s = {PAT_W{1'b0}};
      fill_nxt_s = LEN_W'(0);
    end else if (x_valid) begin
      hist_nxt_s = hist_shift_s;
      if (match_s && (ovl_r == OVL_OFF)) begin
        fill_nxt_s = LEN_W'(0);
      end else begin
        fill_nxt_s = fill_inc_s;
      end
      z_nxt_s = match_s;
    end else begin
      z_nxt_s = 1'b0;
    end
  end

  // Detector state and configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= LEN_W'(0);
      pat_r  <= RST_PAT;
      len_r  <= LEN_W'(RST_LEN);
      ovl_r  <= RST_OVL;
      z_r    <= 1'b0;
    end else begin
      hist_r <= hist_nxt_s;
      fill_r <= fill_nxt_s;
      pat_r  <= pat_nxt_s;
      len_r  <= len_nxt_s;
      ovl_r  <= ovl_nxt_s;
      z_r    <= z_nxt_s;
    end
  end

  assign z = z_r;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter, cleared by a configuration load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (match_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours SEQ_DET_CNT_EN for counter expectations.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int PAT_W = 8;
  localparam int LEN_W = len_w(PAT_W);
  localparam logic [PAT_W-1:0] RST_PAT = 8'b0000_1101;
  localparam int RST_LEN = 4;
  localparam bit RST_OVL = 1'b1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             x = 1'b0, x_valid = 1'b0, cfg_load = 1'b0, cfg_ovl = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             z, z2;
  logic [15:0]      match_cnt;
  logic [1:0]       cnt2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: recent eligible bits, newest at the back.
  bit               m_q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_z;
  int               m_cnt;

  always #5 clk = ~clk;

  seq_det_prog dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .z(z), .match_cnt(match_cnt)
  );

  seq_det_prog #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl),
    .z(z2), .match_cnt(cnt2)
  );

  function automatic int exp_cnt(input int n, input int w);
`ifdef SEQ_DET_CNT_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  function automatic bit model_hit();
    if (m_len == 0 || m_q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pat = RST_PAT; m_len = RST_LEN; m_ovl = RST_OVL; m_z = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step();
    if (cfg_load) begin
      m_pat = cfg_pat;
      m_len = (int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len);
      m_ovl = cfg_ovl;
      m_q.delete();
      m_z = 1'b0;
      m_cnt = 0;
    end else if (x_valid) begin
      m_q.push_back(x);
      if (m_q.size() > PAT_W) void'(m_q.pop_front());
      m_z = model_hit();
      if (m_z) begin
        m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end else begin
      m_z = 1'b0;
    end
  endtask

  // One clock: inputs change at negedge, model follows the posedge, outputs sampled 1 ns later.
  task automatic tick(input logic xv, input logic xb, input logic ld);
    @(negedge clk);
    x_valid = xv; x = xb; cfg_load = ld;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    @(negedge clk);
    cfg_pat = p; cfg_len = l; cfg_ovl = o;
    tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Streams n bits (MSB first) and captures z after each valid sample and during bubbles.
  task automatic run_vec(input logic [31:0] bits, input int n, input bit bubbles,
                         output logic [31:0] zobs, output logic zbub);
    zobs = '0; zbub = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, bits[n-1-i], 1'b0);
      zobs[n-1-i] = z;
      if (bubbles) begin
        tick(1'b0, 1'b0, 1'b0);
        zbub = zbub | z;
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL reset_z got %b want 0", z); end
    n_cmp++; if (match_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", match_cnt); end
    n_cmp++; if (cnt2 !== 2'd0) begin n_err++; $display("FAIL reset_cnt2 got %0d want 0", cnt2); end
  endtask

  task automatic test_default_overlap();
    logic [31:0] zo; logic zb;
    run_vec(32'b1101101, 7, 1'b0, zo, zb);
    n_cmp++; if (zo[6:0] !== 7'b0001001) begin n_err++; $display("FAIL ovl_z got %b want 0001001", zo[6:0]); end
    n_cmp++; if (match_cnt !== 16'(exp_cnt(2, 16))) begin n_err++; $display("FAIL ovl_cnt got %0d want %0d", match_cnt, exp_cnt(2, 16)); end
  endtask

  task automatic test_nonoverlap();
    logic [31:0] zo; logic zb;
    load_cfg(8'b0000_1101, LEN_W'(4), OVL_OFF);
    run_vec(32'b1101101, 7, 1'b0, zo, zb);
    n_cmp++; if (zo[6:0] !== 7'b0001000) begin n_err++; $display("FAIL novl_z got %b want 0001000", zo[6:0]); end
    n_cmp++; if (match_cnt !== 16'(exp_cnt(1, 16))) begin n_err++; $display("FAIL novl_cnt got %0d want %0d", match_cnt, exp_cnt(1, 16)); end
  endtask

  task automatic test_bubbles();
    logic [31:0] zo; logic zb;
    load_cfg(8'b0000_1101, LEN_W'(4), OVL_ON);
    run_vec(32'b1101, 4, 1'b1, zo, zb);
    n_cmp++; if (zo[3:0] !== 4'b0001) begin n_err++; $display("FAIL bub_z got %b want 0001", zo[3:0]); end
    n_cmp++; if (zb !== 1'b0) begin n_err++; $display("FAIL bub_gap got %b want 0", zb); end
  endtask

  task automatic test_len1_saturation();
    logic [31:0] zo; logic zb;
    load_cfg(8'b0000_0001, LEN_W'(1), OVL_ON);
    run_vec(32'b111, 3, 1'b0, zo, zb);
    n_cmp++; if (zo[2:0] !== 3'b111) begin n_err++; $display("FAIL len1_z got %b want 111", zo[2:0]); end
    n_cmp++; if (match_cnt !== 16'(exp_cnt(3, 16))) begin n_err++; $display("FAIL len1_cnt got %0d want %0d", match_cnt, exp_cnt(3, 16)); end
    run_vec(32'b11, 2, 1'b0, zo, zb);
    n_cmp++; if (cnt2 !== 2'(exp_cnt(5, 2))) begin n_err++; $display("FAIL sat_cnt got %0d want %0d", cnt2, exp_cnt(5, 2)); end
    n_cmp++; if (match_cnt !== 16'(exp_cnt(5, 16))) begin n_err++; $display("FAIL sat_wide got %0d want %0d", match_cnt, exp_cnt(5, 16)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] zo; logic zb;
    do_reset();
    run_vec(32'b110, 3, 1'b0, zo, zb);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (z !== 1'b0 || match_cnt !== 16'd0) begin n_err++; $display("FAIL async_rst got z=%b cnt=%0d want 0/0", z, match_cnt); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_vec(32'b11101, 5, 1'b0, zo, zb);
    n_cmp++; if (zo[4:0] !== 5'b00001) begin n_err++; $display("FAIL rstmid_z got %b want 00001", zo[4:0]); end
  endtask

  task automatic test_clamp_len0();
    logic [31:0] zo; logic zb;
    load_cfg(8'hA5, LEN_W'(15), OVL_ON);
    run_vec(32'b10100101, 8, 1'b0, zo, zb);
    n_cmp++; if (zo[7:0] !== 8'b00000001) begin n_err++; $display("FAIL clamp_z got %b want 00000001", zo[7:0]); end
    load_cfg(8'h00, LEN_W'(0), OVL_ON);
    run_vec(32'h0000_0000, 16, 1'b0, zo, zb);
    n_cmp++; if (zo[15:0] !== 16'h0000) begin n_err++; $display("FAIL len0_z got %h want 0000", zo[15:0]); end
  endtask

  task automatic test_load_wins();
    logic [31:0] zo; logic zb;
    load_cfg(8'b0000_1101, LEN_W'(4), OVL_ON);
    run_vec(32'b110, 3, 1'b0, zo, zb);
    @(negedge clk);
    tick(1'b1, 1'b1, 1'b1);
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL ldwin_z got %b want 0", z); end
    run_vec(32'b1101, 4, 1'b0, zo, zb);
    n_cmp++; if (zo[3:0] !== 4'b0001) begin n_err++; $display("FAIL ldwin_seq got %b want 0001", zo[3:0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load_cfg(PAT_W'($urandom), LEN_W'($urandom_range(0, 15)), 1'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        tick(1'b0, 1'($urandom), 1'b0);
      end else begin
        tick(1'b1, 1'($urandom_range(0, 99) < 60), 1'b0);
      end
      n_cmp++;
      if (z !== m_z || z2 !== m_z || match_cnt !== 16'(exp_cnt(m_cnt, 16)) || cnt2 !== 2'(exp_cnt(m_cnt, 2))) begin
        n_err++;
        $display("FAIL rand cyc %0d got z=%b z2=%b cnt=%0d cnt2=%0d want z=%b cnt=%0d cnt2=%0d",
                 i, z, z2, match_cnt, cnt2, m_z, exp_cnt(m_cnt, 16), exp_cnt(m_cnt, 2));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_default_overlap();
    test_nonoverlap();
    test_bubbles();
    test_len1_saturation();
    test_reset_mid();
    test_clamp_len0();
    test_load_wins();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
